// File: rtl/thermo_pkg.sv
// rtl/thermo_pkg.sv - mode encoding and prefix-network helpers for the thermometer engine
package thermo_pkg;

    typedef enum logic [1:0] {
        THERMO_UP    = 2'd0,
        THERMO_DN    = 2'd1,
        THERMO_FIRST = 2'd2,
        THERMO_LAST  = 2'd3
    } thermo_mode_e;

    // Helpers work on a fixed wide vector; callers size-cast to their own width.
    localparam int MAX_W = 64;
    localparam int IDX_W = $clog2(MAX_W);

    function automatic logic [MAX_W-1:0] prefix_level(input logic [MAX_W-1:0] data,
                                                      input int s, input int w);
        logic [MAX_W-1:0] r;
        r = data;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w && ((i >> s) & 1) == 1)
                r[i] = data[i] | data[IDX_W'(((i >> s) << s) - 1)];
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] data, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w)
                r[i] = data[IDX_W'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/thermo_pipe_stage.sv
// rtl/thermo_pipe_stage.sv - one elastic register slice carrying a beat payload
module thermo_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    input  logic          down_adv,
    output logic          adv,
    output logic          valid,
    output logic [PW-1:0] data
);

    assign adv = !valid || down_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid)
                data <= up_data;
        end
    end

endmodule

// File: rtl/thermo_prefix_pipe.sv
// rtl/thermo_prefix_pipe.sv - pipelined prefix-OR thermometer / first / last-bit engine
module thermo_prefix_pipe
    import thermo_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_any,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = $clog2(W);
    // Payload layout: {tag, mode, any, working vector}
    localparam int PW     = TAG_W + 3 + W;

    thermo_mode_e    entry_mode;
    logic [W-1:0]    entry_work;
    logic [PW-1:0]   entry;

    // Downward modes run the same upward network on the mirrored vector.
    always_comb begin
        entry_mode = thermo_mode_e'(in_mode);
        entry_work = in_data;
        if (entry_mode == THERMO_DN || entry_mode == THERMO_LAST)
            entry_work = W'(bit_reverse(MAX_W'(in_data), W));
    end

    assign entry = {in_tag, in_mode, |in_data, entry_work};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int BASE = LEVELS / STAGES;
        localparam int XTRA = LEVELS % STAGES;
        localparam int NL   = BASE + ((k < XTRA) ? 1 : 0);
        localparam int LO   = k * BASE + ((k < XTRA) ? k : XTRA);

        logic          up_v;
        logic [PW-1:0] src;
        logic [W-1:0]  lvl;
        logic [W-1:0]  res;
        logic          down_adv;
        logic          adv_i;
        logic          v_i;
        logic [PW-1:0] q_i;

        if (k == 0) begin : g_head
            assign up_v = in_valid;
            assign src  = entry;
        end else begin : g_body
            assign up_v = g_stage[k-1].v_i;
            assign src  = g_stage[k-1].q_i;
        end

        if (k == STAGES - 1) begin : g_tail
            assign down_adv = out_ready;
        end else begin : g_mid
            assign down_adv = g_stage[k+1].adv_i;
        end

        always_comb begin
            lvl = src[W-1:0];
            for (int s = 0; s < LEVELS; s++) begin
                if (s >= LO && s < LO + NL)
                    lvl = W'(prefix_level(MAX_W'(lvl), s, W));
            end
        end

        if (k == STAGES - 1) begin : g_post
            logic [W-1:0] rev;
            always_comb begin
                rev = W'(bit_reverse(MAX_W'(lvl), W));
                res = lvl;
                case (thermo_mode_e'(src[W+2:W+1]))
                    THERMO_UP:    res = lvl;
                    THERMO_DN:    res = rev;
                    THERMO_FIRST: res = lvl & ~(lvl << 1);
                    THERMO_LAST:  res = rev & ~(rev >> 1);
                    default:      res = lvl;
                endcase
            end
        end else begin : g_pass
            assign res = lvl;
        end

        thermo_pipe_stage #(.PW(PW)) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (up_v),
            .up_data  ({src[PW-1:W], res}),
            .down_adv (down_adv),
            .adv      (adv_i),
            .valid    (v_i),
            .data     (q_i)
        );
    end

    assign in_ready  = g_stage[0].adv_i;
    assign out_valid = g_stage[STAGES-1].v_i;
    assign out_data  = g_stage[STAGES-1].q_i[W-1:0];
    assign out_any   = g_stage[STAGES-1].q_i[W];
    assign out_tag   = g_stage[STAGES-1].q_i[PW-1:W+3];

endmodule

// File: tb/tb_thermo_prefix_pipe.sv
// tb/tb_thermo_prefix_pipe.sv - scoreboard bench for thermo_prefix_pipe across several widths/depths
module tb_thermo_prefix_pipe;

    localparam int NCFG = 7;
    localparam int CW [NCFG] = '{8, 5, 5, 8, 13, 13, 8};
    localparam int CS [NCFG] = '{2, 1, 4, 4, 3, 5, 1};

    typedef struct {
        logic [31:0] d;
        logic        any;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    logic clk;
    int   cyc;
    int   n_pass;
    int   n_total;
    bit   done [NCFG];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: out bit i set if any input bit at or below (UP) / at or above (DN) i is set.
    function automatic int ref_mask(input int w, input int mode, input int din);
        int d;
        int r;
        d = din & ((1 << w) - 1);
        r = 0;
        case (mode)
            0: for (int i = 0; i < w; i++) if ((d & ((2 << i) - 1)) != 0) r |= (1 << i);
            1: for (int i = 0; i < w; i++) if ((d >> i) != 0) r |= (1 << i);
            2: r = d & (-d);
            default: for (int i = 0; i < w; i++) if ((d >> i) == 1) r = (1 << i);
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = CW[g];
        localparam int S = CS[g];

        logic         rst_n, in_valid, in_ready, out_valid, out_ready, out_any;
        logic [W-1:0] in_data, out_data;
        logic [1:0]   in_mode;
        logic [3:0]   in_tag, out_tag;
        exp_t         q [$];
        bit           strict, bp_en, use_const, presented, prev_stall;
        logic [31:0]  const_d;
        logic         const_any;
        logic [W+4:0] prev_out;
        int           acc_cnt;

        thermo_prefix_pipe #(.W(W), .STAGES(S), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_mode   (in_mode),
            .in_tag    (in_tag),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_any   (out_any),
            .out_tag   (out_tag)
        );

        always @(negedge clk) begin
            int           lat;
            exp_t         e;
            logic [W+4:0] ev;
            if (!rst_n) begin
                q.delete();
                presented  = 0;
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    check(out_valid && {out_tag, out_any, out_data} == prev_out,
                          $sformatf("cfg%0d hold", g), {out_valid, out_tag, out_any, out_data}, {1'b1, prev_out});
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check(0, $sformatf("cfg%0d unexpected output", g), out_tag, 0);
                    end else begin
                        if (!presented) begin
                            lat = cyc - q[0].cyc;
                            check(strict ? (lat == S) : (lat >= S), $sformatf("cfg%0d latency", g), lat, S);
                            presented = 1;
                        end
                        if (out_ready) begin
                            e  = q.pop_front();
                            ev = {e.tag, e.any, e.d[W-1:0]};
                            check({out_tag, out_any, out_data} == ev, $sformatf("cfg%0d result", g),
                                  {out_tag, out_any, out_data}, ev);
                            presented = 0;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_tag, out_any, out_data};
                if (in_valid && in_ready) begin
                    e.d   = use_const ? const_d : ref_mask(W, int'(in_mode), int'(in_data));
                    e.any = use_const ? const_any : (in_data != 0);
                    e.tag = in_tag;
                    e.cyc = cyc;
                    q.push_back(e);
                    acc_cnt++;
                end
            end
        end

        task automatic send(input logic [W-1:0] d, input logic [1:0] m, input logic [3:0] t);
            int n;
            n = 0;
            in_valid = 1'b1;
            in_data  = d;
            in_mode  = m;
            in_tag   = t;
            forever begin
                if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_ready) break;
                n++;
                if (n > 200) begin
                    check(0, $sformatf("cfg%0d in_ready timeout", g), 0, 1);
                    break;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
        endtask

        task automatic idle(input int n);
            in_valid = 1'b0;
            repeat (n) begin
                if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            in_valid  = 1'b0;
            bp_en     = 0;
            out_ready = 1'b1;
            while (q.size() != 0 && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            check(q.size() == 0, $sformatf("cfg%0d drain", g), q.size(), 0);
        endtask

        task automatic init();
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            in_data   = '0;
            in_mode   = 2'd0;
            in_tag    = 4'd0;
            out_ready = 1'b1;
            bp_en     = 0;
            strict    = 1;
            use_const = 0;
            repeat (3) @(posedge clk);
            #1;
            check({out_valid, out_any, out_tag, out_data} == '0, $sformatf("cfg%0d reset outputs", g),
                  {out_valid, out_any, out_tag, out_data}, 0);
            rst_n = 1'b1;
            @(negedge clk);
            check(in_ready == 1'b1, $sformatf("cfg%0d in_ready after reset", g), in_ready, 1);
            @(posedge clk); #1;
        endtask

        task automatic sweep();
            logic [W-1:0] d;
            for (int ph = 0; ph < 2; ph++) begin
                strict = (ph == 0);
                bp_en  = (ph == 1);
                for (int i = 0; i < 140; i++) begin
                    d = W'($urandom);
                    case ($urandom_range(0, 7))
                        0: d = '0;
                        1: d = '1;
                        default: ;
                    endcase
                    send(d, 2'($urandom_range(0, 3)), 4'(i));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                drain();
            end
        endtask

        if (g == 0) begin : g_dir
            task automatic directed();
                logic [7:0] din  [12] = '{8'h24, 8'h24, 8'h24, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00,
                                          8'hFF, 8'hFF, 8'hFF, 8'hFF};
                logic [7:0] dexp [12] = '{8'hFC, 8'h3F, 8'h04, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
                                          8'hFF, 8'hFF, 8'h01, 8'h80};
                logic [7:0] cur_d;
                logic [1:0] cur_m;
                int         k, a0, cnt;
                bit         acc;
                for (int i = 0; i < 12; i++) begin
                    use_const = 1;
                    const_d   = 32'(dexp[i]);
                    const_any = (i < 4 || i >= 8);
                    send(din[i], 2'(i % 4), 4'(i));
                end
                use_const = 0;
                idle(4);
                for (int t = 0; t < 16; t++) send(8'($urandom), 2'($urandom_range(0, 3)), 4'(t));
                idle(4);
                strict    = 0;
                out_ready = 1'b0;
                a0        = acc_cnt;
                k         = 0;
                cur_d     = 8'($urandom);
                cur_m     = 2'($urandom_range(0, 3));
                in_valid  = 1'b1;
                in_data   = cur_d;
                in_mode   = cur_m;
                in_tag    = 4'(k);
                repeat (5) begin
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk); #1;
                    if (acc) begin
                        k++;
                        cur_d   = 8'($urandom);
                        cur_m   = 2'($urandom_range(0, 3));
                        in_data = cur_d;
                        in_mode = cur_m;
                        in_tag  = 4'(k);
                    end
                end
                @(negedge clk);
                check(acc_cnt - a0 == S, "stall accepted count", acc_cnt - a0, S);
                check(in_ready == 1'b0, "in_ready when full", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
                send(cur_d, cur_m, 4'(k));
                for (int t = k + 1; t < 6; t++) send(8'($urandom), 2'($urandom_range(0, 3)), 4'(t));
                idle(6);
                check(q.size() == 0, "stall beats delivered", q.size(), 0);
                strict = 1;
                send(8'($urandom), 2'd0, 4'd1);
                send(8'($urandom), 2'd1, 4'd2);
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                check(out_valid == 1'b0, "async reset out_valid", out_valid, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                cnt   = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid) cnt++;
                end
                check(cnt == 0, "stale output after reset", cnt, 0);
                check(in_ready == 1'b1, "in_ready after mid reset", in_ready, 1);
                @(posedge clk); #1;
            endtask

            initial begin
                init();
                directed();
                sweep();
                done[g] = 1;
            end
        end else begin : g_rnd
            initial begin
                init();
                sweep();
                done[g] = 1;
            end
        end
    end

    initial begin
        bit all;
        int n;
        n_pass  = 0;
        n_total = 0;
        n       = 0;
        all     = 0;
        while (!all && n < 60000) begin
            @(posedge clk);
            n++;
            all = 1;
            for (int i = 0; i < NCFG; i++) if (!done[i]) all = 0;
        end
        if (!all) check(0, "global timeout", n, 60000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
